// File: rtl/moving_avg_filter.sv
// moving_avg_filter: running-sum average over the last 2**WIN_LOG2 accepted samples.
// Define MAF_MEDIAN3_EN to put a 3-tap spike-removing median in front (latency 3).
module moving_avg_filter #(
  parameter int DATA_W = 16,
  parameter int WIN_LOG2 = 4
) (
  input  logic                     CLK,
  input  logic                     RESET_n,
  input  logic                     CLEAR,
  input  logic                     IN_VALID,
  input  logic signed [DATA_W-1:0] DATA_IN,
  output logic                     OUT_VALID,
  output logic signed [DATA_W-1:0] DATA_OUT,
  output logic                     FILLED
);
  localparam int N = 2**WIN_LOG2;
  localparam int SW = DATA_W + WIN_LOG2;
  localparam int CW = WIN_LOG2 + 1;
  logic signed [DATA_W-1:0] ring [N];
  logic [WIN_LOG2-1:0] ptr;
  logic [CW-1:0] cnt;
  logic signed [SW-1:0] sum;
  logic pend;
  logic acc;
  logic signed [DATA_W-1:0] din;
`ifdef MAF_MEDIAN3_EN
  logic signed [DATA_W-1:0] t0, t1, med;
  logic med_v;
  function automatic logic signed [DATA_W-1:0] med3(input logic signed [DATA_W-1:0] a, b, c);
    logic signed [DATA_W-1:0] lo, hi;
    lo = a < b ? a : b;
    hi = a < b ? b : a;
    return hi < c ? hi : (lo > c ? lo : c);
  endfunction
  always_ff @(posedge CLK) begin
    if (!RESET_n || CLEAR) begin
      t0 <= '0;
      t1 <= '0;
      med <= '0;
      med_v <= 1'b0;
    end else begin
      med_v <= IN_VALID;
      if (IN_VALID) begin
        med <= med3(DATA_IN, t0, t1);
        t1 <= t0;
        t0 <= DATA_IN;
      end
    end
  end
  assign acc = med_v;
  assign din = med;
`else
  assign acc = IN_VALID;
  assign din = DATA_IN;
`endif
  // cnt saturates at N, so its top bit alone marks a full window
  assign FILLED = cnt[WIN_LOG2];
  always_ff @(posedge CLK) begin
    if (!RESET_n || CLEAR) begin
      for (int i = 0; i < N; i++) ring[i] <= '0;
      ptr <= '0;
      cnt <= '0;
      sum <= '0;
      pend <= 1'b0;
      OUT_VALID <= 1'b0;
      if (!RESET_n) DATA_OUT <= '0;
    end else begin
      pend <= acc && (cnt[WIN_LOG2] || &cnt[WIN_LOG2-1:0]);
      OUT_VALID <= pend;
      if (pend) DATA_OUT <= DATA_W'((sum + SW'(N / 2)) >>> WIN_LOG2);
      if (acc) begin
        sum <= sum + SW'(din) - SW'(ring[ptr]);
        ring[ptr] <= din;
        ptr <= ptr + 1'b1;
        cnt <= cnt + CW'(!cnt[WIN_LOG2]);
      end
    end
  end
endmodule
